// File: rtl/counter_handshake_arbiter.sv
// Round-robin arbiter that lends one asynchronous dual-rail 2-bit counter to
// several clocked clients. Each grant runs one 4-phase req/ack cycle and
// returns the decoded count to the granted client with a done pulse.
module counter_handshake_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] cli_req,
    output logic [NUM_REQ-1:0] cli_grant,
    output logic [NUM_REQ-1:0] cli_done,
    output logic [1:0]         cli_value,
    output logic               cli_err,
    output logic               req,
    input  logic               ack,
    input  logic               a0,
    input  logic               a1,
    input  logic               b0,
    input  logic               b1
);

    localparam int         PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TMAX      = 8'(TIMEOUT - 1);
    localparam logic [1:0] HOLD_INIT = 2'(SYNC_STAGES);

    typedef enum logic [1:0] {IDLE, RISE, FALL, DONE} state_t;

    state_t             state, state_n;
    logic [4:0]         sync_q [SYNC_STAGES];
    logic               ack_s, a0_s, a1_s, b0_s, b1_s;
    logic               a_valid, b_valid, a_ill, b_ill;
    logic [PW-1:0]      ptr, win, win_next;
    logic               found;
    logic [PW:0]        cand;
    logic [7:0]         tmr;
    logic               tmo;
    logic [1:0]         hold;
    logic [NUM_REQ-1:0] grant_q;
    logic [1:0]         val_q;
    logic               err_q;
    logic               start, lat_val, set_err;

    // Synchronizer chains for the asynchronous handshake and rail inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {ack, a0, a1, b0, b1};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {ack_s, a0_s, a1_s, b0_s, b1_s} = sync_q[SYNC_STAGES-1];
    assign a_valid = a0_s ^ a1_s;
    assign b_valid = b0_s ^ b1_s;
    assign a_ill   = a0_s & a1_s;
    assign b_ill   = b0_s & b1_s;

    // Round-robin scan starting at the pointer, wrapping at NUM_REQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
            if (!found && cli_req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
        win_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end

    assign tmo = (tmr == TMAX);

    // Next-state and per-transition control strobes
    always_comb begin
        state_n = state;
        start   = 1'b0;
        lat_val = 1'b0;
        set_err = 1'b0;
        case (state)
            IDLE: begin
                // the hold window covers the synchronizer refill after reset,
                // so a counter still acknowledging is never mistaken for idle
                if (hold == '0 && !ack_s && found) begin
                    state_n = RISE;
                    start   = 1'b1;
                end
            end
            RISE: begin
                if (ack_s && (a_ill || b_ill)) begin
                    state_n = FALL;
                    set_err = 1'b1;
                end else if (ack_s && a_valid && b_valid) begin
                    state_n = FALL;
                    lat_val = 1'b1;
                end else if (tmo) begin
                    state_n = FALL;
                    set_err = 1'b1;
                end
            end
            FALL: begin
                if (!ack_s) begin
                    state_n = DONE;
                end else if (tmo) begin
                    state_n = DONE;
                    set_err = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register, grant/pointer bookkeeping and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant_q <= '0;
            req     <= 1'b0;
            val_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            req   <= (state_n == RISE);
            if (start) begin
                grant_q <= NUM_REQ'(1) << win;
                ptr     <= win_next;
                val_q   <= '0;
                err_q   <= 1'b0;
            end
            if (lat_val) val_q <= {b1_s, a1_s};
            if (set_err) err_q <= 1'b1;
            if (state == DONE) grant_q <= '0;
        end
    end

    // Per-state timeout counter, cleared on every state change
    always_ff @(posedge clk) begin
        if (rst || state_n != state) tmr <= '0;
        else if (!tmo)               tmr <= tmr + 1'b1;
    end

    // Post-reset grant hold-off while the synchronizers refill
    always_ff @(posedge clk) begin
        if (rst)             hold <= HOLD_INIT;
        else if (hold != '0) hold <= hold - 1'b1;
    end

    assign cli_grant = grant_q;
    assign cli_done  = (state == DONE) ? grant_q : '0;
    assign cli_value = (state == DONE) ? val_q : '0;
    assign cli_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_counter_handshake_arbiter.sv
// Scoreboard bench: expected {client, value, err} results are queued when a
// request is issued and compared when the arbiter pulses cli_done.
module tb_counter_handshake_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 16;
    localparam int SS   = 2;

    typedef struct packed {
        logic [1:0] idx;
        logic [1:0] val;
        logic       err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] cli_req;
    logic [NREQ-1:0] cli_grant, cli_done;
    logic [1:0]      cli_value;
    logic            cli_err;
    logic            req, ack, a0, a1, b0, b1;

    int         cmode;   // 0 normal, 1 illegal a rails, 2 no ack, 3 ack stuck high
    logic [1:0] cval;
    exp_t       sbq [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    counter_handshake_arbiter #(
        .NUM_REQ    (NREQ),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cli_req  (cli_req),
        .cli_grant(cli_grant),
        .cli_done (cli_done),
        .cli_value(cli_value),
        .cli_err  (cli_err),
        .req      (req),
        .ack      (ack),
        .a0       (a0),
        .a1       (a1),
        .b0       (b0),
        .b1       (b1)
    );

    always #5 clk = ~clk;

    // Counter model: responds to req with no delay in normal mode
    always_comb begin
        ack = 1'b0; a0 = 1'b0; a1 = 1'b0; b0 = 1'b0; b1 = 1'b0;
        case (cmode)
            1: begin ack = req; a0 = req; a1 = req; b0 = req; b1 = 1'b0; end
            2: begin ack = 1'b0; end
            3: begin ack = 1'b1; a1 = cval[0]; a0 = ~cval[0]; b1 = cval[1]; b0 = ~cval[1]; end
            default: begin
                ack = req;
                a1 = req & cval[0]; a0 = req & ~cval[0];
                b1 = req & cval[1]; b0 = req & ~cval[1];
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: pop and compare at every done pulse, and watch grant shape
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (|cli_grant) chk("grant_onehot", 32'($onehot(cli_grant)), 1);
            if (|cli_done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(cli_done), 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_vec", 32'(cli_done), 32'(1) << e.idx);
                    chk("value", 32'(cli_value), 32'(e.val));
                    chk("err", 32'(cli_err), 32'(e.err));
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
    endtask

    // Waits for the client's done; counts req-high cycles and req-low cycles before done
    task automatic wait_done(input logic [1:0] idx, input int bound,
                             output int cyc, output int hi, output int lo);
        bit found = 1'b0;
        bit seen  = 1'b0;
        cyc = 0; hi = 0; lo = 0;
        while (!found && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
            if (cli_done[idx]) found = 1'b1;
            else if (req) begin hi++; seen = 1'b1; end
            else if (seen) lo++;
        end
        chk("done_seen", 32'(found), 1);
        cli_req[idx] = 1'b0;
    endtask

    task automatic txn(input logic [1:0] idx, input logic [1:0] v, input logic e,
                       output int cyc, output int hi, output int lo);
        cval = v;
        sbq.push_back('{idx: idx, val: (e && cmode != 3) ? 2'b00 : v, err: e});
        cli_req[idx] = 1'b1;
        wait_done(idx, 400, cyc, hi, lo);
        tick(2);
    endtask

    initial begin
        int cyc, hi, lo, nrise, lowcnt, gapbad, gseen;
        bit prev_req, seen_hi;
        rst = 1'b1; cli_req = '0; cmode = 0; cval = 2'b00;
        tick(3);
        chk("rst_req", 32'(req), 0);
        chk("rst_grant", 32'(cli_grant), 0);
        chk("rst_done", 32'(cli_done), 0);
        chk("rst_value", 32'(cli_value), 0);
        chk("rst_err", 32'(cli_err), 0);
        rst = 1'b0;
        tick(5);

        // Single client, immediate counter: a1=1, b0=1 -> value 01
        txn(2'd0, 2'b01, 1'b0, cyc, hi, lo);
        chk("single_done_cycle", 32'(cyc + 1), 2 * SS + 4);
        chk("single_req_hi", 32'(hi), SS + 1);
        chk("single_fall_len", 32'(lo), SS + 1);

        // Contention: all four held, round-robin from reset
        do_reset();
        cval = 2'b10;
        for (int k = 0; k < 5; k++) sbq.push_back('{idx: 2'(k % 4), val: 2'b10, err: 1'b0});
        cli_req = 4'b1111;
        cyc = 0; nrise = 0; lowcnt = 0; gapbad = 0; prev_req = 1'b0; seen_hi = 1'b0;
        while (sbq.size() != 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (req && !prev_req) begin
                nrise++;
                if (seen_hi && lowcnt < 1) gapbad++;
                lowcnt = 0;
            end
            if (req) seen_hi = 1'b1;
            else lowcnt++;
            prev_req = req;
        end
        cli_req = '0;
        chk("contention_drained", 32'(sbq.size()), 0);
        chk("contention_txns", 32'(nrise), 5);
        chk("contention_req_gap", 32'(gapbad), 0);
        tick(4);

        // Illegal a rails when ack rises
        cmode = 1;
        txn(2'd1, 2'b00, 1'b1, cyc, hi, lo);
        chk("illegal_idle_req", 32'(req), 0);
        chk("illegal_idle_grant", 32'(cli_grant), 0);
        cmode = 0;

        // RISE timeout: ack never rises
        cmode = 2;
        txn(2'd2, 2'b11, 1'b1, cyc, hi, lo);
        chk("rise_tmo_req_hi", 32'(hi), TO);
        chk("rise_tmo_fall_len", 32'(lo), 1);
        cmode = 0;

        // FALL timeout: ack stays high after rising
        cval = 2'b11;
        sbq.push_back('{idx: 2'd3, val: 2'b11, err: 1'b1});
        cli_req[3] = 1'b1;
        cyc = 0;
        while (!req && cyc < 50) begin @(posedge clk); #1; cyc++; end
        cmode = 3;
        wait_done(2'd3, 400, cyc, hi, lo);
        chk("fall_tmo_len", 32'(lo), TO);
        cmode = 0;
        tick(4);

        // Reset while RISE with ack held high
        cval = 2'b01;
        cli_req[3] = 1'b1;
        cyc = 0;
        while (!req && cyc < 50) begin @(posedge clk); #1; cyc++; end
        cmode = 3;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_req", 32'(req), 0);
        chk("mid_rst_grant", 32'(cli_grant), 0);
        chk("mid_rst_done", 32'(cli_done), 0);
        gseen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (|cli_grant) gseen++;
        end
        chk("no_grant_ack_high", 32'(gseen), 0);
        cmode = 0;
        sbq.push_back('{idx: 2'd3, val: 2'b01, err: 1'b0});
        wait_done(2'd3, 400, cyc, hi, lo);
        tick(2);

        // Count sweep 0..3
        for (int v = 0; v < 4; v++) begin
            txn(2'd0, 2'(v), 1'b0, cyc, hi, lo);
            chk("sweep_req_hi", 32'(hi), SS + 1);
        end

        tick(5);
        chk("final_queue", 32'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
